// File: rtl/game_level_ctrl.sv
// Level/round controller for the number-guessing game: tracks level, round, wrong
// guesses and a per-round countdown, and asks the generator for a new secret each round.
module game_level_ctrl #(
    parameter int NUM_LEVELS       = 3,
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int BASE_GUESSES     = 3,
    parameter int GUESS_STEP       = 1,
    parameter int BASE_TIME        = 30,
    parameter int TIME_STEP        = 30,
    parameter bit RETRY_EN         = 1'b1,
    parameter int LW               = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int GW               = 4,
    parameter int TW               = 8,
    parameter int RW               = $clog2(ROUNDS_PER_LEVEL + 1)
) (
    input  logic          clk,
    input  logic          restart,
    input  logic          tick,
    input  logic          confirm,
    input  logic          correct,
    output logic [LW-1:0] level,
    output logic [GW-1:0] max_guess,
    output logic [LW:0]   max_digit,
    output logic [GW-1:0] guesses_left,
    output logic [TW-1:0] time_left,
    output logic [RW-1:0] round,
    output logic          new_target,
    output logic          playing,
    output logic          win,
    output logic          gameover,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        PLAY     = 2'd1,
        WIN      = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] wrong;
    logic [TW-1:0] round_time;
    logic [RW-1:0] roundn;
    logic          time_expiring;

    // Handshake: confirm is a one-cycle strobe; correct is only meaningful in the
    // cycle confirm is high and is ignored otherwise. There is no back-pressure.
    always_comb begin
        max_guess     = GW'(BASE_GUESSES + int'(level) * GUESS_STEP);
        max_digit     = {1'b0, level} + (LW+1)'(1);
        guesses_left  = max_guess - wrong;
        round_time    = TW'(BASE_TIME + int'(level) * TIME_STEP);
        roundn        = round + RW'(1);
        time_expiring = tick && (time_left == TW'(1));
    end

    // new_target is masked while restart is held so the flags read idle during reset.
    assign new_target = (state == LOAD) && !restart;
    assign playing    = (state == PLAY);
    assign win        = (state == WIN);
    assign gameover   = (state == GAMEOVER);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (restart) begin
            state     <= LOAD;
            level     <= '0;
            round     <= '0;
            wrong     <= '0;
            time_left <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    time_left <= round_time;
                    wrong     <= '0;
                    state     <= PLAY;
                end
                PLAY: begin
                    if (confirm && correct) begin
                        if (roundn == RW'(ROUNDS_PER_LEVEL)) begin
                            if (level == LW'(NUM_LEVELS - 1)) begin
                                state <= WIN;
                            end else begin
                                level <= level + LW'(1);
                                round <= '0;
                                state <= LOAD;
                            end
                        end else begin
                            round <= roundn;
                            state <= LOAD;
                        end
                    end else if (confirm) begin
                        wrong <= wrong + GW'(1);
                        if (tick) begin
                            time_left <= time_left - TW'(1);
                        end
                        if ((wrong + GW'(1) == max_guess) || time_expiring) begin
                            state <= GAMEOVER;
                        end
                    end else if (tick) begin
                        time_left <= time_left - TW'(1);
                        if (time_expiring) begin
                            state <= GAMEOVER;
                        end
                    end
                end
                WIN: begin
                    state <= WIN;
                end
                GAMEOVER: begin
                    if (RETRY_EN && confirm) begin
                        round <= '0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed bench for game_level_ctrl: one default instance (retry enabled) and one
// with retry disabled, both driven by the same stimulus.
module tb_game_level_ctrl;

    logic clk = 1'b0;
    logic restart = 1'b0;
    logic tick = 1'b0;
    logic confirm = 1'b0;
    logic correct = 1'b0;

    logic [1:0] level, nr_level;
    logic [3:0] max_guess, nr_max_guess;
    logic [2:0] max_digit, nr_max_digit;
    logic [3:0] guesses_left, nr_guesses_left;
    logic [7:0] time_left, nr_time_left;
    logic [1:0] round, nr_round;
    logic new_target, playing, win, gameover;
    logic nr_new_target, nr_playing, nr_win, nr_gameover;
    logic [1:0] state_dbg, nr_state_dbg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    game_level_ctrl dut (
        .clk(clk), .restart(restart), .tick(tick), .confirm(confirm), .correct(correct),
        .level(level), .max_guess(max_guess), .max_digit(max_digit),
        .guesses_left(guesses_left), .time_left(time_left), .round(round),
        .new_target(new_target), .playing(playing), .win(win), .gameover(gameover),
        .state_dbg(state_dbg)
    );

    game_level_ctrl #(.RETRY_EN(1'b0)) dut_nr (
        .clk(clk), .restart(restart), .tick(tick), .confirm(confirm), .correct(correct),
        .level(nr_level), .max_guess(nr_max_guess), .max_digit(nr_max_digit),
        .guesses_left(nr_guesses_left), .time_left(nr_time_left), .round(nr_round),
        .new_target(nr_new_target), .playing(nr_playing), .win(nr_win),
        .gameover(nr_gameover), .state_dbg(nr_state_dbg)
    );

    // Drivers: inputs change 1 ns after a rising edge; outputs are sampled on negedges.
    task automatic cyc(input logic c, input logic cor, input logic t);
        confirm = c; correct = cor; tick = t;
        @(posedge clk); #1;
        confirm = 1'b0; correct = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Leaves the design in its LOAD cycle with restart already released.
    task automatic do_reset();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        restart = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (new_target !== 1'b0) begin bad++; $display("FAIL rst_new_target got=%0b exp=0", new_target); end
        total++; if ({playing, win, gameover} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {playing, win, gameover}); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        total++; if (max_guess !== 4'd3) begin bad++; $display("FAIL rst_max_guess got=%0d exp=3", max_guess); end
        total++; if (guesses_left !== 4'd3) begin bad++; $display("FAIL rst_guesses_left got=%0d exp=3", guesses_left); end
        total++; if (max_digit !== 3'd1) begin bad++; $display("FAIL rst_max_digit got=%0d exp=1", max_digit); end
        total++; if (time_left !== 8'd0) begin bad++; $display("FAIL rst_time_left got=%0d exp=0", time_left); end
        restart = 1'b0;
        #1;
        total++; if (new_target !== 1'b1) begin bad++; $display("FAIL load_new_target got=%0b exp=1", new_target); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL load_state got=%0d exp=0", state_dbg); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (new_target !== 1'b0) begin bad++; $display("FAIL play_new_target got=%0b exp=0", new_target); end
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL play_flag got=%0b exp=1", playing); end
        total++; if (time_left !== 8'd30) begin bad++; $display("FAIL play_time got=%0d exp=30", time_left); end
    endtask

    task automatic test_correct();
        do_reset(); idle(1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            total++; if (new_target !== 1'b1) begin bad++; $display("FAIL cor_new_target_%0d got=%0b exp=1", k, new_target); end
            total++; if (round !== 2'((k + 1) % 3)) begin bad++; $display("FAIL cor_round_%0d got=%0d exp=%0d", k, round, (k + 1) % 3); end
            idle(1);
        end
        @(negedge clk);
        total++; if (level !== 2'd1) begin bad++; $display("FAIL cor_level got=%0d exp=1", level); end
        total++; if (max_guess !== 4'd4) begin bad++; $display("FAIL cor_max_guess got=%0d exp=4", max_guess); end
        total++; if (max_digit !== 3'd2) begin bad++; $display("FAIL cor_max_digit got=%0d exp=2", max_digit); end
        total++; if (time_left !== 8'd60) begin bad++; $display("FAIL cor_time got=%0d exp=60", time_left); end
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL cor_playing got=%0b exp=1", playing); end
    endtask

    task automatic test_wrong();
        do_reset(); idle(1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            total++; if (guesses_left !== 4'(2 - k)) begin bad++; $display("FAIL wr_left_%0d got=%0d exp=%0d", k, guesses_left, 2 - k); end
            total++; if (gameover !== (k == 2)) begin bad++; $display("FAIL wr_gameover_%0d got=%0b exp=%0b", k, gameover, k == 2); end
        end
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (time_left !== 8'd30) begin bad++; $display("FAIL go_tick_ignored got=%0d exp=30", time_left); end
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (new_target !== 1'b1) begin bad++; $display("FAIL retry_load got=%0b exp=1", new_target); end
        total++; if (nr_gameover !== 1'b1) begin bad++; $display("FAIL noretry_hold got=%0b exp=1", nr_gameover); end
        idle(1);
        @(negedge clk);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL retry_play got=%0b exp=1", playing); end
        total++; if ({level, round} !== 4'd0) begin bad++; $display("FAIL retry_level_round got=%0d/%0d exp=0/0", level, round); end
        total++; if (guesses_left !== 4'd3) begin bad++; $display("FAIL retry_left got=%0d exp=3", guesses_left); end
        total++; if (nr_gameover !== 1'b1) begin bad++; $display("FAIL noretry_hold2 got=%0b exp=1", nr_gameover); end
    endtask

    task automatic test_timeout();
        do_reset(); idle(1);
        for (int k = 0; k < 29; k++) cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (time_left !== 8'd1) begin bad++; $display("FAIL to_time29 got=%0d exp=1", time_left); end
        cyc(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (round !== 2'd1) begin bad++; $display("FAIL to_round got=%0d exp=1", round); end
        total++; if (gameover !== 1'b0) begin bad++; $display("FAIL to_no_gameover got=%0b exp=0", gameover); end
        idle(1);
        @(negedge clk);
        total++; if (time_left !== 8'd30) begin bad++; $display("FAIL to_reload got=%0d exp=30", time_left); end
        do_reset(); idle(1);
        for (int k = 0; k < 29; k++) cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (gameover !== 1'b0) begin bad++; $display("FAIL to_early got=%0b exp=0", gameover); end
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (gameover !== 1'b1) begin bad++; $display("FAIL to_gameover got=%0b exp=1", gameover); end
        total++; if (time_left !== 8'd0) begin bad++; $display("FAIL to_zero got=%0d exp=0", time_left); end
    endtask

    task automatic test_back_to_back();
        do_reset(); idle(1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (guesses_left !== 4'd1) begin bad++; $display("FAIL b2b_left got=%0d exp=1", guesses_left); end
        cyc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (gameover !== 1'b1) begin bad++; $display("FAIL b2b_gameover got=%0b exp=1", gameover); end
        total++; if (time_left !== 8'd29) begin bad++; $display("FAIL b2b_tick_wrong got=%0d exp=29", time_left); end
    endtask

    task automatic test_win();
        do_reset(); idle(1);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (k < 8) idle(1);
        end
        @(negedge clk);
        total++; if (win !== 1'b1) begin bad++; $display("FAIL win_flag got=%0b exp=1", win); end
        total++; if (level !== 2'd2) begin bad++; $display("FAIL win_level got=%0d exp=2", level); end
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (win !== 1'b1) begin bad++; $display("FAIL win_hold got=%0b exp=1", win); end
        total++; if ({level, round} !== {2'd2, 2'd2}) begin bad++; $display("FAIL win_counters got=%0d/%0d exp=2/2", level, round); end
        total++; if (guesses_left !== 4'd5) begin bad++; $display("FAIL win_left got=%0d exp=5", guesses_left); end
        total++; if (time_left !== 8'd90) begin bad++; $display("FAIL win_time got=%0d exp=90", time_left); end
        do_reset();
        @(negedge clk);
        total++; if (new_target !== 1'b1 || level !== 2'd0) begin bad++; $display("FAIL win_restart got=%0b/%0d exp=1/0", new_target, level); end
    endtask

    task automatic test_restart_mid();
        do_reset(); idle(1);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            idle(1);
        end
        for (int k = 0; k < 45; k++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (level !== 2'd2 || time_left !== 8'd45 || guesses_left !== 4'd3) begin
            bad++; $display("FAIL mid_setup got=%0d/%0d/%0d exp=2/45/3", level, time_left, guesses_left); end
        do_reset();
        @(negedge clk);
        total++; if (state_dbg !== 2'd0 || new_target !== 1'b1) begin bad++; $display("FAIL mid_load got=%0d/%0b exp=0/1", state_dbg, new_target); end
        total++; if ({level, round} !== 4'd0) begin bad++; $display("FAIL mid_level_round got=%0d/%0d exp=0/0", level, round); end
        total++; if (guesses_left !== 4'd3) begin bad++; $display("FAIL mid_left got=%0d exp=3", guesses_left); end
        idle(1);
        @(negedge clk);
        total++; if (time_left !== 8'd30) begin bad++; $display("FAIL mid_time got=%0d exp=30", time_left); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_timeout();
        test_back_to_back();
        test_win();
        test_restart_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
